// File: rtl/uart_rx_edge_bit_sampler.sv
// rtl/uart_rx_edge_bit_sampler.sv - UART RX oversampling timebase and 3-sample majority-vote bit sampler
module uart_rx_edge_bit_sampler (
    input  logic       clk,
    input  logic       rst,
    input  logic       RX_IN,
    input  logic [5:0] Prescale,
    input  logic       enable,
    input  logic       dat_samp_en,
    output logic [4:0] edge_cnt,
    output logic [3:0] bit_cnt,
    output logic       sampled_bit,
    output logic       sample_valid,
    output logic       samp_noisy
);

    logic [4:0] r_edge_cnt;
    logic [3:0] r_bit_cnt;
    logic       r_s0;
    logic       r_s1;
    logic       r_sampled_bit;
    logic       r_sample_valid;
    logic       r_samp_noisy;

    logic [5:0] w_edge_ext;
    logic [5:0] w_half;
    logic       w_last_tick;
    logic       w_tick_s0;
    logic       w_tick_s1;
    logic       w_tick_vote;
    logic       w_sample_on;
    logic       w_vote;
    logic       w_agree;

    // Compare in 6 bits so P-1 = 31 and h-3 etc. never truncate.
    assign w_edge_ext  = {1'b0, r_edge_cnt};
    assign w_half      = {1'b0, Prescale[5:1]};
    assign w_last_tick = (w_edge_ext == (Prescale - 6'd1));
    assign w_tick_s0   = (w_edge_ext == (w_half - 6'd3));
    assign w_tick_s1   = (w_edge_ext == (w_half - 6'd2));
    assign w_tick_vote = (w_edge_ext == (w_half - 6'd1));
    assign w_sample_on = enable & dat_samp_en;

    // Third sample is the live line value at the vote edge.
    assign w_vote  = (r_s0 & r_s1) | (r_s0 & RX_IN) | (r_s1 & RX_IN);
    assign w_agree = (r_s0 == r_s1) && (r_s1 == RX_IN);

    // Tick and bit-period counters; bit count saturates at 15.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_edge_cnt <= 5'd0;
            r_bit_cnt  <= 4'd0;
        end else if (!enable) begin
            r_edge_cnt <= 5'd0;
            r_bit_cnt  <= 4'd0;
        end else if (w_last_tick) begin
            r_edge_cnt <= 5'd0;
            if (r_bit_cnt != 4'd15) begin
                r_bit_cnt <= r_bit_cnt + 4'd1;
            end
        end else begin
            r_edge_cnt <= r_edge_cnt + 5'd1;
        end
    end

    // Capture two samples before centre, vote on the third; strobe is one cycle wide.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s0           <= 1'b1;
            r_s1           <= 1'b1;
            r_sampled_bit  <= 1'b1;
            r_sample_valid <= 1'b0;
            r_samp_noisy   <= 1'b0;
        end else begin
            r_sample_valid <= 1'b0;
            r_samp_noisy   <= 1'b0;
            if (w_sample_on) begin
                if (w_tick_s0) begin
                    r_s0 <= RX_IN;
                end
                if (w_tick_s1) begin
                    r_s1 <= RX_IN;
                end
                if (w_tick_vote) begin
                    r_sampled_bit  <= w_vote;
                    r_sample_valid <= 1'b1;
                    r_samp_noisy   <= ~w_agree;
                end
            end
        end
    end

    assign edge_cnt     = r_edge_cnt;
    assign bit_cnt      = r_bit_cnt;
    assign sampled_bit  = r_sampled_bit;
    assign sample_valid = r_sample_valid;
    assign samp_noisy   = r_samp_noisy;

endmodule

// File: tb/tb_uart_rx_edge_bit_sampler.sv
// tb/tb_uart_rx_edge_bit_sampler.sv - directed vector bench for uart_rx_edge_bit_sampler
module tb_uart_rx_edge_bit_sampler;

    logic       clk;
    logic       rst;
    logic       RX_IN;
    logic [5:0] Prescale;
    logic       enable;
    logic       dat_samp_en;
    logic [4:0] edge_cnt;
    logic [3:0] bit_cnt;
    logic       sampled_bit;
    logic       sample_valid;
    logic       samp_noisy;

    uart_rx_edge_bit_sampler dut (
        .clk          (clk),
        .rst          (rst),
        .RX_IN        (RX_IN),
        .Prescale     (Prescale),
        .enable       (enable),
        .dat_samp_en  (dat_samp_en),
        .edge_cnt     (edge_cnt),
        .bit_cnt      (bit_cnt),
        .sampled_bit  (sampled_bit),
        .sample_valid (sample_valid),
        .samp_noisy   (samp_noisy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One row per clock cycle: inputs held during the cycle, outputs expected during it.
    typedef struct {
        logic       rst;
        logic       en;
        logic       dse;
        logic       rx;
        logic [5:0] psc;
        logic       chk;
        logic [4:0] e_edge;
        logic [3:0] e_bit;
        logic       e_sb;
        logic       e_sv;
        logic       e_nz;
    } vec_t;

    vec_t tbl[$];
    logic last_sb;
    int   total;
    int   bad;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic e, input logic d, input logic x, input logic [5:0] p);
        rst         = r;
        enable      = e;
        dat_samp_en = d;
        RX_IN       = x;
        Prescale    = p;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add_row(input logic r, input logic e, input logic d, input logic x, input logic [5:0] p,
                           input logic c, input logic [4:0] ee, input logic [3:0] eb,
                           input logic es, input logic ev, input logic en_);
        vec_t v;
        v.rst = r; v.en = e; v.dse = d; v.rx = x; v.psc = p; v.chk = c;
        v.e_edge = ee; v.e_bit = eb; v.e_sb = es; v.e_sv = ev; v.e_nz = en_;
        tbl.push_back(v);
    endtask

    task automatic add_idle(input int n, input logic [5:0] p);
        for (int i = 0; i < n; i++) begin
            add_row(1'b0, 1'b0, 1'b1, 1'b1, p, 1'b1, 5'd0, 4'd0, last_sb, 1'b0, 1'b0);
        end
    endtask

    // Frame of nbits bit periods (line value bits[b]); enable drops in the final row.
    task automatic add_frame(input logic [5:0] p, input logic [31:0] bits, input int nbits,
                             input logic dse, input int gl_bit, input int gl_tick);
        int   h;
        int   b;
        int   t;
        logic x;
        logic sb;
        logic sv;
        logic nz;
        h = int'(p) / 2;
        for (int k = 0; k <= nbits * int'(p); k++) begin
            b = k / int'(p);
            t = k % int'(p);
            x = (b < nbits) ? bits[b] : 1'b1;
            if (b == gl_bit && t == gl_tick) x = ~x;
            if (!dse)          sb = last_sb;
            else if (t >= h)   sb = bits[b];
            else if (b > 0)    sb = bits[b-1];
            else               sb = last_sb;
            sv = dse && (t == h);
            nz = sv && (b == gl_bit) && (gl_tick >= h - 3) && (gl_tick <= h - 1);
            add_row(1'b0, (k < nbits * int'(p)), dse, x, p, 1'b1,
                    5'(t), (b > 15) ? 4'd15 : 4'(b), sb, sv, nz);
        end
        if (dse) last_sb = bits[nbits-1];
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        last_sb = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 1'b1, 6'd8);

        // Reset, then reset values visible with enable low.
        add_row(1'b1, 1'b1, 1'b1, 1'b0, 6'd8, 1'b0, 5'd0, 4'd0, 1'b1, 1'b0, 1'b0);
        add_row(1'b0, 1'b0, 1'b0, 1'b1, 6'd8, 1'b1, 5'd0, 4'd0, 1'b1, 1'b0, 1'b0);
        add_idle(2, 6'd8);
        // P=8, start 0, data 0x55 LSB first, stop 1.
        add_frame(6'd8, 32'h0000_02AA, 10, 1'b1, -1, 0);
        add_idle(2, 6'd16);
        // P=16, high bits with a one-tick low glitch at tick 6 of bit 1.
        add_frame(6'd16, 32'h0000_0003, 2, 1'b1, 1, 6);
        add_idle(2, 6'd32);
        // P=32, bit 0 high, bit 1 low.
        add_frame(6'd32, 32'h0000_0001, 2, 1'b1, -1, 0);
        add_idle(2, 6'd8);
        // Sampling disabled: no strobe, sampled_bit holds the earlier 0.
        add_frame(6'd8, 32'h0000_0003, 2, 1'b0, -1, 0);
        add_idle(2, 6'd8);
        // 20 bit periods: bit_cnt saturates at 15.
        add_frame(6'd8, 32'h000F_FFFF, 20, 1'b1, -1, 0);
        add_idle(2, 6'd8);

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].en, tbl[i].dse, tbl[i].rx, tbl[i].psc);
            if (tbl[i].chk) begin
                chk($sformatf("row%0d_edge_cnt", i), 8'(edge_cnt), 8'(tbl[i].e_edge));
                chk($sformatf("row%0d_bit_cnt", i), 8'(bit_cnt), 8'(tbl[i].e_bit));
                chk($sformatf("row%0d_sampled_bit", i), 8'(sampled_bit), 8'(tbl[i].e_sb));
                chk($sformatf("row%0d_sample_valid", i), 8'(sample_valid), 8'(tbl[i].e_sv));
                chk($sformatf("row%0d_samp_noisy", i), 8'(samp_noisy), 8'(tbl[i].e_nz));
            end
            step();
        end

        // enable dropped at tick h-1 of bit 3 (bits 1,0,1,0): no vote, counters clear.
        begin
            logic [3:0] pat;
            pat = 4'b0101;
            drive(1'b0, 1'b0, 1'b1, 1'b1, 6'd8);
            step();
            for (int k = 0; k < 27; k++) begin
                drive(1'b0, 1'b1, 1'b1, pat[k/8], 6'd8);
                step();
            end
            chk("drop_pre_edge", 8'(edge_cnt), 8'd3);
            chk("drop_pre_bit", 8'(bit_cnt), 8'd3);
            chk("drop_pre_sb", 8'(sampled_bit), 8'd1);
            drive(1'b0, 1'b0, 1'b1, 1'b0, 6'd8);
            step();
            chk("drop_edge", 8'(edge_cnt), 8'd0);
            chk("drop_bit", 8'(bit_cnt), 8'd0);
            chk("drop_sv", 8'(sample_valid), 8'd0);
            chk("drop_sb", 8'(sampled_bit), 8'd1);
            for (int k = 0; k < 3; k++) begin
                step();
                chk("drop_hold_sv", 8'(sample_valid), 8'd0);
                chk("drop_hold_sb", 8'(sampled_bit), 8'd1);
            end
        end

        // Reset at tick h-1 of bit 5 (line low) beats the pending vote.
        for (int k = 0; k < 43; k++) begin
            drive(1'b0, 1'b1, 1'b1, (k >= 32) ? 1'b0 : 1'((k / 8) % 2), 6'd8);
            step();
        end
        chk("rst_pre_edge", 8'(edge_cnt), 8'd3);
        chk("rst_pre_bit", 8'(bit_cnt), 8'd5);
        chk("rst_pre_sb", 8'(sampled_bit), 8'd0);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 6'd8);
        step();
        chk("rst_edge", 8'(edge_cnt), 8'd0);
        chk("rst_bit", 8'(bit_cnt), 8'd0);
        chk("rst_sb", 8'(sampled_bit), 8'd1);
        chk("rst_sv", 8'(sample_valid), 8'd0);
        chk("rst_nz", 8'(samp_noisy), 8'd0);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 6'd8);
        for (int i = 1; i <= 8; i++) begin
            step();
            if (i == 4) begin
                chk("post_rst_sv", 8'(sample_valid), 8'd1);
                chk("post_rst_sb", 8'(sampled_bit), 8'd1);
                chk("post_rst_edge4", 8'(edge_cnt), 8'd4);
            end
        end
        chk("post_rst_edge", 8'(edge_cnt), 8'd0);
        chk("post_rst_bit", 8'(bit_cnt), 8'd1);

        drive(1'b0, 1'b0, 1'b0, 1'b1, 6'd8);
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
